// File: rtl/lsu_pkg.sv
// ============================================================================
// lsu_pkg : shared encodings and helpers for the load/store controller
// Revision: 1.0
// ============================================================================
`default_nettype none

package lsu_pkg;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;
  localparam int         ST_BIT = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  localparam logic [1:0] LANE_B0 = 2'd0;
  localparam logic [1:0] LANE_B1 = 2'd1;
  localparam logic [1:0] LANE_B2 = 2'd2;
  localparam logic [1:0] LANE_B3 = 2'd3;
  localparam logic       LANE_H_LO = 1'b0;
  localparam logic       LANE_H_HI = 1'b1;

  // Unsigned sizes are load-only; any size outside the table is illegal.
  function automatic logic op_illegal(input logic [3:0] op);
    logic size_ok;
    size_ok = (op[2:0] == OP_B) || (op[2:0] == OP_H) || (op[2:0] == OP_W) ||
              (op[2:0] == OP_BU) || (op[2:0] == OP_HU);
    return !size_ok || (op[ST_BIT] && op[2]);
  endfunction

  function automatic logic misaligned(input logic [2:0] size, input logic [1:0] lo);
    return (((size == OP_H) || (size == OP_HU)) && lo[0]) ||
           ((size == OP_W) && (lo != 2'b00));
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_lane_align.sv
// ============================================================================
// lsu_lane_align : byte/halfword lane extraction for loads and lane merge
//                  for read-modify-write stores (little-endian)
// Revision: 1.0
// ============================================================================
`default_nettype none

module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] mem_rd_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  size_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merged_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte   = 8'h00;
    w_half   = 16'h0000;
    load_o   = mem_rd_i;
    merged_o = mem_rd_i;

    case (addr_lo_i)
      LANE_B0: w_byte = mem_rd_i[7:0];
      LANE_B1: w_byte = mem_rd_i[15:8];
      LANE_B2: w_byte = mem_rd_i[23:16];
      LANE_B3: w_byte = mem_rd_i[31:24];
      default: w_byte = 8'h00;
    endcase

    case (addr_lo_i[1])
      LANE_H_LO: w_half = mem_rd_i[15:0];
      LANE_H_HI: w_half = mem_rd_i[31:16];
      default:   w_half = 16'h0000;
    endcase

    case (size_i)
      OP_B:    load_o = {{24{w_byte[7]}}, w_byte};
      OP_BU:   load_o = {24'h000000, w_byte};
      OP_H:    load_o = {{16{w_half[15]}}, w_half};
      OP_HU:   load_o = {16'h0000, w_half};
      default: load_o = mem_rd_i;
    endcase

    case (size_i)
      OP_B, OP_BU: begin
        case (addr_lo_i)
          LANE_B0: merged_o[7:0]   = wdata_i[7:0];
          LANE_B1: merged_o[15:8]  = wdata_i[7:0];
          LANE_B2: merged_o[23:16] = wdata_i[7:0];
          LANE_B3: merged_o[31:24] = wdata_i[7:0];
          default: merged_o        = mem_rd_i;
        endcase
      end
      OP_H, OP_HU: begin
        case (addr_lo_i[1])
          LANE_H_LO: merged_o[15:0]  = wdata_i[15:0];
          LANE_H_HI: merged_o[31:16] = wdata_i[15:0];
          default:   merged_o        = mem_rd_i;
        endcase
      end
      default: merged_o = wdata_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu_mem_ctrl.sv
// ============================================================================
// lsu_mem_ctrl : load/store controller in front of a word-wide single-strobe
//                data memory; sub-word stores use read-modify-write
// Revision: 1.0
// ============================================================================
`default_nettype none

module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS  = 64,
  parameter int LITTLE_END = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic        mem_rw,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam logic [32:0] c_MEM_BYTES = 33'(MEM_WORDS) * 33'd4;

  if (LITTLE_END != 1) begin : g_endian_check
    $error("lsu_mem_ctrl: only LITTLE_END=1 is supported");
  end

  state_e      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] wd_q, wd_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        rw_q;

  logic        w_req_err;
  logic [31:0] w_load;
  logic [31:0] w_merged;

  assign w_req_err = op_illegal(req_op) ||
                     misaligned(req_op[2:0], req_addr[1:0]) ||
                     ({1'b0, req_addr} >= c_MEM_BYTES);

  lsu_lane_align u_align (
    .mem_rd_i  (mem_rd),
    .addr_lo_i (addr_q[1:0]),
    .size_i    (op_q[2:0]),
    .wdata_i   (wdata_q),
    .load_o    (w_load),
    .merged_o  (w_merged)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wd_d    = wd_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = 32'h0;
          err_d   = w_req_err;
          if (w_req_err) begin
            state_d = S_RESP;
          end else if (req_op[ST_BIT] && (req_op[2:0] == OP_W)) begin
            wd_d    = req_wdata;
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        if (op_q[ST_BIT]) begin
          wd_d    = w_merged;
          state_d = S_WRITE;
        end else begin
          rdata_d = w_load;
          state_d = S_RESP;
        end
      end
      S_WRITE: state_d = S_RESP;
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The write strobe is a flop fed by the next state so it never glitches
  // and drops the instant reset asserts.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      op_q    <= 4'h0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      wd_q    <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      rw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wd_q    <= wd_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      rw_q    <= (state_d == S_WRITE);
    end
  end

  assign req_ready = (state_q == S_IDLE) && !RST;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_rw    = rw_q;
  assign mem_wd    = wd_q;

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_ctrl.sv
// ============================================================================
// tb_lsu_mem_ctrl : randomized self-checking bench for lsu_mem_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_lsu_mem_ctrl;

  localparam int          MEM_WORDS = 64;
  localparam logic [32:0] LIMIT     = 33'd256;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = 4'h0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic        mem_rw;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  always #5 CLK = ~CLK;

  lsu_mem_ctrl #(.MEM_WORDS(MEM_WORDS), .LITTLE_END(1)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_rw(mem_rw), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  function automatic logic [31:0] seed_word(input int i);
    return (32'h9E3779B9 * 32'(i + 1)) ^ 32'h5A5A0000;
  endfunction

  // Memory behind the controller: combinational read, write on rising edge.
  logic [31:0] mem [0:MEM_WORDS-1];
  logic        mem_loaded = 1'b0;
  assign mem_rd = ({1'b0, mem_addr} < LIMIT) ? mem[mem_addr[7:2]] : 32'h0;

  always @(posedge CLK) begin
    if (!mem_loaded) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= seed_word(i);
      mem_loaded <= 1'b1;
    end else if (mem_rw && ({1'b0, mem_addr} < LIMIT)) begin
      mem[mem_addr[7:2]] <= mem_wd;
    end
  end

  logic [31:0] ref_mem [0:MEM_WORDS-1];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_rdata = 32'h0;
  logic        exp_err = 1'b0;
  int          exp_lat = 0;
  int          exp_wr = 0;
  logic [31:0] exp_waddr = 32'h0;
  logic [31:0] exp_wword = 32'h0;
  int          writes_seen = 0;
  logic [31:0] last_wd = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: what a request must do, straight from the op/address rules.
  function automatic void model(input logic [3:0] op, input logic [31:0] addr,
                                input logic [31:0] wdata);
    int          sz;
    bit          st, legal, mis;
    int          k;
    logic [31:0] w, b, h, nw;
    sz = int'(op[2:0]);
    st = op[3];
    k  = int'(addr % 4);
    legal = (sz == 0 || sz == 1 || sz == 2 || sz == 4 || sz == 5) && !(st && sz >= 4);
    mis   = ((sz == 1 || sz == 5) && (k % 2 == 1)) || (sz == 2 && k != 0);
    exp_err   = !legal || mis || ({1'b0, addr} >= LIMIT);
    exp_rdata = 32'h0;
    exp_wr    = 0;
    exp_waddr = 32'h0;
    exp_wword = 32'h0;
    if (exp_err) begin
      exp_lat = 1;
      return;
    end
    w = ref_mem[addr / 4];
    b = (w >> (8 * k)) & 32'hFF;
    h = (w >> (8 * k)) & 32'hFFFF;
    if (!st) begin
      exp_lat = 2;
      case (sz)
        0: exp_rdata = (b >= 128) ? b - 32'd256 : b;
        1: exp_rdata = (h >= 32768) ? h - 32'd65536 : h;
        4: exp_rdata = b;
        5: exp_rdata = h;
        default: exp_rdata = w;
      endcase
    end else begin
      case (sz)
        0: begin nw = (w & ~(32'hFF << (8 * k))) | ((wdata & 32'hFF) << (8 * k)); exp_lat = 3; end
        1: begin nw = (w & ~(32'hFFFF << (8 * k))) | ((wdata & 32'hFFFF) << (8 * k)); exp_lat = 3; end
        default: begin nw = wdata; exp_lat = 2; end
      endcase
      exp_wr    = 1;
      exp_waddr = addr - 32'(k);
      exp_wword = nw;
      ref_mem[addr / 4] = nw;
    end
  endfunction

  // Advance to the next falling edge and check every meaningful output there.
  task automatic tick();
    @(negedge CLK);
    if (!RST) begin
      chk("addr_align", {30'b0, mem_addr[1:0]}, 32'h0);
      if (rsp_valid) begin
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, exp_err});
      end
      if (mem_rw) begin
        writes_seen++;
        last_wd = mem_wd;
        chk("wr_addr", mem_addr, exp_waddr);
        chk("wr_data", mem_wd, exp_wword);
      end
    end
  endtask

  task automatic do_req(input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input int hold,
                        output logic [31:0] rd, output logic er, output int lat);
    int guard;
    int wbase;
    guard = 0;
    while (!req_ready && guard < 50) begin
      tick();
      guard++;
    end
    chk("req_ready_wait", {31'b0, req_ready}, 32'h1);
    model(op, addr, wdata);
    wbase     = writes_seen;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("writes", 32'(writes_seen - wbase), 32'(exp_wr));
    rd = rsp_rdata;
    er = rsp_err;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", {31'b0, rsp_valid}, 32'h1);
      chk("hold_ready", {31'b0, req_ready}, 32'h0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("back_idle_ready", {31'b0, req_ready}, 32'h1);
    chk("back_idle_valid", {31'b0, rsp_valid}, 32'h0);
  endtask

  logic [3:0]  ops [0:7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100,
                             4'b0101, 4'b1000, 4'b1001, 4'b1010};
  logic [31:0] rd;
  logic        er;
  int          lat;
  int          wbase;

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = seed_word(i);

    repeat (3) @(negedge CLK);
    chk("rst_rw", {31'b0, mem_rw}, 32'h0);
    chk("rst_valid", {31'b0, rsp_valid}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wd", mem_wd, 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_err", {31'b0, rsp_err}, 32'h0);
    RST = 1'b0;
    tick();
    chk("post_rst_ready", {31'b0, req_ready}, 32'h1);

    do_req(4'b1010, 32'h10, 32'hDEADBEEF, 0, rd, er, lat);
    chk("sw_lat", 32'(lat), 32'd2);
    chk("sw_mem", last_wd, 32'hDEADBEEF);
    do_req(4'b0010, 32'h10, 32'h0, 0, rd, er, lat);
    chk("lw_data", rd, 32'hDEADBEEF);
    chk("lw_err", {31'b0, er}, 32'h0);
    chk("lw_lat", 32'(lat), 32'd2);
    do_req(4'b0000, 32'h13, 32'h0, 0, rd, er, lat);
    chk("lb_data", rd, 32'hFFFFFFDE);
    do_req(4'b0100, 32'h13, 32'h0, 0, rd, er, lat);
    chk("lbu_data", rd, 32'h000000DE);
    do_req(4'b0001, 32'h10, 32'h0, 0, rd, er, lat);
    chk("lh_data", rd, 32'hFFFFBEEF);
    do_req(4'b0101, 32'h12, 32'h0, 0, rd, er, lat);
    chk("lhu_data", rd, 32'h0000DEAD);
    do_req(4'b1000, 32'h11, 32'h55, 0, rd, er, lat);
    chk("sb_merge", last_wd, 32'hDEAD55EF);
    chk("sb_lat", 32'(lat), 32'd3);

    do_req(4'b0010, 32'h12, 32'h0, 0, rd, er, lat);
    chk("err_lw_mis", {31'b0, er}, 32'h1);
    chk("err_lw_mis_lat", 32'(lat), 32'd1);
    do_req(4'b0001, 32'h01, 32'h0, 0, rd, er, lat);
    chk("err_lh_mis", {31'b0, er}, 32'h1);
    do_req(4'b1100, 32'h20, 32'hFF, 0, rd, er, lat);
    chk("err_illegal", {31'b0, er}, 32'h1);
    do_req(4'b0010, 32'h100, 32'h0, 0, rd, er, lat);
    chk("err_range", {31'b0, er}, 32'h1);
    chk("err_range_lat", 32'(lat), 32'd1);

    do_req(4'b0010, 32'h10, 32'h0, 5, rd, er, lat);
    chk("hold_data", rd, 32'hDEAD55EF);

    for (int n = 0; n < 200; n++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 7) == 0) ? 4'($urandom) : ops[$urandom_range(0, 7)];
      do_req(op, 32'($urandom_range(0, 279)), $urandom, int'($urandom_range(0, 2)),
             rd, er, lat);
    end

    // Abort a halfword store during its read phase.
    wbase     = writes_seen;
    exp_wr    = 0;
    req_valid = 1'b1;
    req_op    = 4'b1001;
    req_addr  = 32'h22;
    req_wdata = 32'h1234;
    tick();
    req_valid = 1'b0;
    #2 RST = 1'b1;
    #1;
    chk("abort_rw", {31'b0, mem_rw}, 32'h0);
    chk("abort_valid", {31'b0, rsp_valid}, 32'h0);
    tick();
    chk("abort_rst_wd", mem_wd, 32'h0);
    chk("abort_rst_addr", mem_addr, 32'h0);
    #1 RST = 1'b0;
    tick();
    chk("abort_ready", {31'b0, req_ready}, 32'h1);
    chk("abort_valid2", {31'b0, rsp_valid}, 32'h0);
    chk("abort_writes", 32'(writes_seen - wbase), 32'h0);
    chk("abort_word", mem[8], ref_mem[8]);
    do_req(4'b0010, 32'h20, 32'h0, 0, rd, er, lat);
    chk("abort_reload", rd, ref_mem[8]);

    for (int i = 0; i < MEM_WORDS; i++) chk("mem_final", mem[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
